note_lane_engine: RTL and testbench
===================================

Name: note_lane_engine

Overview:
Parametrised note-highway core for the rhythm game. It holds up to SLOTS falling notes in each of NUM_LANES lanes and spawns notes from a chart source through a valid/ready handshake. It advances the notes on each frame tick, judges strums against the hit bar, and keeps score and streak. It also answers per-pixel lane/bar queries for the VGA colour mux, so the fixed four-lane, hard-wired note logic moves into one reusable block.

Parameters:
NUM_LANES, 4, number of lanes (1..8)
SLOTS, 4, note slots per lane
Y_W, 10, note y-coordinate width
SCREEN_H, 480, y at which a note is retired
NOTE_H, 50, note height (and width) in pixels
HIT_Y, 350, hit bar top y
HIT_H, 20, hit bar height
LANE_X0, 170, left x of lane 0
LANE_PITCH, 100, x spacing between lanes
SPEED_W, 4, width of speed input
SCORE_W, 16, score width

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame; moves notes
speed  in  SPEED_W  pixels moved per frame_tick
spawn_valid  in  1  chart source has a spawn request
spawn_lanes  in  NUM_LANES  bitmask of lanes receiving a new note
spawn_ready  out  1  engine can accept a spawn
strum  in  1  one-cycle strum pulse (already debounced)
buttons  in  NUM_LANES  fret buttons held, sampled on strum
hit_pulse  out  1  one-cycle pulse on a correct strum
miss_pulse  out  1  one-cycle pulse on a miss
hit_lanes  out  NUM_LANES  mask of the last hit
score  out  SCORE_W  accumulated score
streak  out  8  consecutive hits
px_x  in  10  pixel x query
px_y  in  9  pixel y query
pix_lane  out  NUM_LANES  pixel lies on a note in lane l
pix_bar  out  1  pixel lies on the hit bar

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Slot state per lane/slot: valid bit and y[Y_W-1:0] (top edge of the note).
- Reset, applied on any cycle including mid-operation:
  - all slots go invalid next edge;
  - score=0, streak=0, hit_lanes=0, hit_pulse=0, miss_pulse=0, pix_lane=0, pix_bar=0;
  - events pending in the same cycle are dropped.
- spawn_ready is combinational: 1 iff every lane has at least one free slot (so it is 1 after reset).
- Spawn is accepted on an edge where spawn_valid && spawn_ready:
  - each set lane takes its lowest-index free slot, with valid=1 and y=0;
  - spawn_lanes=0 is accepted with no effect;
  - free slots are judged on pre-edge state, so slots cleared this same cycle are not reused.
- Window: in_win(slot) = valid && y+NOTE_H > HIT_Y && y < HIT_Y+HIT_H. Compare at Y_W+1 bits. win_mask[l] = any in_win slot in lane l.
- Strum, evaluated on pre-move state:
  - win_mask==0: strum is ignored (no pulse, no state change).
  - buttons==win_mask: hit.
    - The lowest-index in-window slot per masked lane is cleared.
    - score += popcount(win_mask)*mult, where mult = 1+min(streak>>3, 3). Score saturates at all-ones.
    - streak increments, saturating at 255.
    - hit_lanes=win_mask, and hit_pulse fires next cycle.
  - Otherwise: miss. streak=0, miss_pulse fires, no slot is cleared.
- frame_tick: each valid slot not cleared this cycle does y += speed, computed at Y_W+1 bits. If the result >= SCREEN_H, the slot goes invalid, miss_pulse fires and streak=0.
- speed=0 freezes all notes.
- A spawn in the same cycle as frame_tick lands at y=0 and is not moved that cycle.
- A hit and a fall-off in the same cycle: score is added, then streak is forced to 0; both pulses assert.
- Multiple misses in one cycle produce a single miss_pulse.
- Pixel query, registered with 1-cycle latency from px_x/px_y:
  - pix_lane[l] = 1 iff px_x is in [LANE_X0+l*LANE_PITCH, +NOTE_H) and some valid slot in lane l has y <= px_y < y+NOTE_H;
  - pix_bar = 1 iff px_y is in [HIT_Y, HIT_Y+HIT_H) and px_x is in [LANE_X0, LANE_X0+(NUM_LANES-1)*LANE_PITCH+NOTE_H).

Test Plan:
- Reset, spawn_lanes=0001, speed=10, 31 frame_ticks (y=310), strum with buttons=0001 -> hit_pulse 1 cycle, hit_lanes=0001, score=1, streak=1, lane 0 empty.
- Same setup, strum with buttons=0011 -> miss_pulse, streak=0, note stays and keeps moving; strum at y=0 (outside window) -> no pulse.
- Spawn lane 2, speed=10, 48 ticks -> on the tick reaching y=480 the slot clears, miss_pulse 1 cycle, streak=0.
- Four spawns on lane 2 -> spawn_ready=0; a fifth spawn_valid is not accepted; after the first note falls off, spawn_ready=1.
- Eight consecutive single-lane hits then a two-lane chord hit -> score=8+2*2=12, streak=9.
- After spawning lane 1, query px=(270,10) -> pix_lane=0010 one cycle later; (270,60) -> 0; (200,355) -> pix_bar=1; reset mid-flight -> all outputs 0 next cycle.

Source files
------------

// File: rtl/note_lane_engine.sv
// rtl/note_lane_engine.sv - note highway core: spawn, move, strum judge, score/streak, pixel query
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   frame_tick, speed    per-frame advance of every live note by speed pixels
//   spawn_valid/_lanes   chart source request; spawn_ready says every lane has a free slot
//   strum, buttons       strum pulse and held frets, judged against notes inside the hit window
//   hit_pulse/miss_pulse one-cycle judgement pulses; hit_lanes holds the last hit mask
//   score, streak        accumulated score (saturating) and consecutive hit count (saturating)
//   px_x, px_y           pixel query; pix_lane/pix_bar answer one cycle later
module note_lane_engine #(
    parameter int NUM_LANES  = 4,
    parameter int SLOTS      = 4,
    parameter int Y_W        = 10,
    parameter int SCREEN_H   = 480,
    parameter int NOTE_H     = 50,
    parameter int HIT_Y      = 350,
    parameter int HIT_H      = 20,
    parameter int LANE_X0    = 170,
    parameter int LANE_PITCH = 100,
    parameter int SPEED_W    = 4,
    parameter int SCORE_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [SPEED_W-1:0]   speed,
    input  logic                 spawn_valid,
    input  logic [NUM_LANES-1:0] spawn_lanes,
    output logic                 spawn_ready,
    input  logic                 strum,
    input  logic [NUM_LANES-1:0] buttons,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [NUM_LANES-1:0] hit_lanes,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           streak,
    input  logic [9:0]           px_x,
    input  logic [8:0]           px_y,
    output logic [NUM_LANES-1:0] pix_lane,
    output logic                 pix_bar
);
    // Window and retirement compares run one bit wider than y so y+NOTE_H cannot wrap.
    localparam int YE = Y_W + 1;
    localparam logic [YE-1:0] NOTE_H_E   = YE'(NOTE_H);
    localparam logic [YE-1:0] HIT_Y_E    = YE'(HIT_Y);
    localparam logic [YE-1:0] BAR_END_E  = YE'(HIT_Y + HIT_H);
    localparam logic [YE-1:0] SCREEN_H_E = YE'(SCREEN_H);
    localparam int BAR_X_END = LANE_X0 + (NUM_LANES - 1) * LANE_PITCH + NOTE_H;

    logic [NUM_LANES-1:0][SLOTS-1:0]          slot_valid, slot_valid_nxt;
    logic [NUM_LANES-1:0][SLOTS-1:0][Y_W-1:0] slot_y, slot_y_nxt;
    logic [NUM_LANES-1:0][SLOTS-1:0]          in_win;
    logic [NUM_LANES-1:0]                     win_mask;
    logic [NUM_LANES-1:0]                     lane_free;

    logic                 spawn_fire;
    logic                 do_hit;
    logic                 do_miss;
    logic                 fell;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_nxt;
    logic [7:0]           streak_nxt;
    logic [NUM_LANES-1:0] hit_lanes_nxt;
    logic [NUM_LANES-1:0] pix_lane_nxt;
    logic                 pix_bar_nxt;

    // Hit window and free-slot status, all from pre-edge state.
    always_comb begin
        in_win    = '0;
        win_mask  = '0;
        lane_free = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_free[l] = ~&slot_valid[l];
            for (int s = 0; s < SLOTS; s++) begin
                in_win[l][s] = slot_valid[l][s]
                            && (({1'b0, slot_y[l][s]} + NOTE_H_E) > HIT_Y_E)
                            && ({1'b0, slot_y[l][s]} < BAR_END_E);
            end
            win_mask[l] = |in_win[l];
        end
    end

    assign spawn_ready = &lane_free;
    assign spawn_fire  = spawn_valid && spawn_ready;
    // A strum with nothing in the window is not judged at all.
    assign do_hit      = strum && (win_mask != '0) && (buttons == win_mask);
    assign do_miss     = strum && (win_mask != '0) && (buttons != win_mask);

    // Per-slot next state: hit clear wins over movement; spawns only use slots free before the edge.
    always_comb begin : slot_next
        logic           hit_taken;
        logic           free_taken;
        logic [YE-1:0]  moved;
        slot_valid_nxt = slot_valid;
        slot_y_nxt     = slot_y;
        fell           = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            hit_taken  = 1'b0;
            free_taken = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                moved = {1'b0, slot_y[l][s]} + YE'(speed);
                if (do_hit && in_win[l][s] && !hit_taken) begin
                    slot_valid_nxt[l][s] = 1'b0;
                    hit_taken            = 1'b1;
                end else if (slot_valid[l][s] && frame_tick) begin
                    if (moved >= SCREEN_H_E) begin
                        slot_valid_nxt[l][s] = 1'b0;
                        fell                 = 1'b1;
                    end else begin
                        slot_y_nxt[l][s] = moved[Y_W-1:0];
                    end
                end
                if (spawn_fire && spawn_lanes[l] && !slot_valid[l][s] && !free_taken) begin
                    slot_valid_nxt[l][s] = 1'b1;
                    slot_y_nxt[l][s]     = '0;
                    free_taken           = 1'b1;
                end
            end
        end
    end

    // Score multiplier steps up every 8 streak, capped at 4x; a fall-off in the same cycle still zeroes streak.
    always_comb begin : score_next
        int pop;
        int mult;
        pop = 0;
        for (int l = 0; l < NUM_LANES; l++) begin
            pop = pop + int'(win_mask[l]);
        end
        mult          = (streak[7:3] >= 5'd3) ? 4 : 1 + int'(streak[7:3]);
        score_sum     = {1'b0, score} + (SCORE_W + 1)'(pop * mult);
        score_nxt     = score;
        streak_nxt    = streak;
        hit_lanes_nxt = hit_lanes;
        if (do_hit) begin
            score_nxt     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            streak_nxt    = (streak == 8'hFF) ? streak : streak + 8'd1;
            hit_lanes_nxt = win_mask;
        end
        if (do_miss || fell) begin
            streak_nxt = '0;
        end
    end

    // Pixel hit test against the current (pre-edge) note positions.
    always_comb begin : pixel_next
        int  x_lo;
        logic x_hit;
        pix_lane_nxt = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            x_lo  = LANE_X0 + l * LANE_PITCH;
            x_hit = (int'(px_x) >= x_lo) && (int'(px_x) < x_lo + NOTE_H);
            for (int s = 0; s < SLOTS; s++) begin
                if (x_hit && slot_valid[l][s]
                    && (int'(px_y) >= int'(slot_y[l][s]))
                    && (int'(px_y) < int'(slot_y[l][s]) + NOTE_H)) begin
                    pix_lane_nxt[l] = 1'b1;
                end
            end
        end
        pix_bar_nxt = (int'(px_y) >= HIT_Y) && (int'(px_y) < HIT_Y + HIT_H)
                   && (int'(px_x) >= LANE_X0) && (int'(px_x) < BAR_X_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            slot_y     <= '0;
            score      <= '0;
            streak     <= '0;
            hit_lanes  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            pix_lane   <= '0;
            pix_bar    <= 1'b0;
        end else begin
            slot_valid <= slot_valid_nxt;
            slot_y     <= slot_y_nxt;
            score      <= score_nxt;
            streak     <= streak_nxt;
            hit_lanes  <= hit_lanes_nxt;
            hit_pulse  <= do_hit;
            miss_pulse <= do_miss || fell;
            pix_lane   <= pix_lane_nxt;
            pix_bar    <= pix_bar_nxt;
        end
    end
endmodule

// File: tb/tb_note_lane_engine.sv
// tb/tb_note_lane_engine.sv - scoreboard bench for note_lane_engine with directed and random stimulus
module tb_note_lane_engine;
    localparam int NL = 4;
    localparam int NS = 4;
    localparam int SCREEN_H = 480;
    localparam int NOTE_H = 50;
    localparam int HIT_Y = 350;
    localparam int HIT_H = 20;
    localparam int LANE_X0 = 170;
    localparam int LANE_PITCH = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic [3:0]    speed;
    logic          spawn_valid;
    logic [NL-1:0] spawn_lanes;
    logic          spawn_ready;
    logic          strum;
    logic [NL-1:0] buttons;
    logic          hit_pulse;
    logic          miss_pulse;
    logic [NL-1:0] hit_lanes;
    logic [15:0]   score;
    logic [7:0]    streak;
    logic [9:0]    px_x;
    logic [8:0]    px_y;
    logic [NL-1:0] pix_lane;
    logic          pix_bar;

    always #5 clk = ~clk;

    note_lane_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed(speed),
        .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes), .spawn_ready(spawn_ready),
        .strum(strum), .buttons(buttons), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .hit_lanes(hit_lanes), .score(score), .streak(streak),
        .px_x(px_x), .px_y(px_y), .pix_lane(pix_lane), .pix_bar(pix_bar)
    );

    typedef struct {
        logic      hp;
        logic      mp;
        logic [3:0] hl;
        int        sc;
        int        st;
        logic [3:0] pl;
        logic      pb;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: notes as plain (valid, y) pairs per lane, rules applied with integer arithmetic.
    bit m_valid[NL][NS];
    int m_y[NL][NS];
    int m_score;
    int m_streak;
    int m_hit_lanes;

    function automatic bit note_in_window(input int y);
        return (y + NOTE_H > HIT_Y) && (y < HIT_Y + HIT_H);
    endfunction

    function automatic int model_win();
        int w = 0;
        for (int l = 0; l < NL; l++)
            for (int s = 0; s < NS; s++)
                if (m_valid[l][s] && note_in_window(m_y[l][s])) w |= (1 << l);
        return w;
    endfunction

    function automatic bit model_ready();
        for (int l = 0; l < NL; l++) begin
            bit any_free = 0;
            for (int s = 0; s < NS; s++) if (!m_valid[l][s]) any_free = 1;
            if (!any_free) return 0;
        end
        return 1;
    endfunction

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step(input bit tick, input int spd, input bit sv, input int sl,
                        input bit st, input int bt, input int x, input int y);
        exp_t e;
        bit   pv[NL][NS];
        int   py[NL][NS];
        bit   cleared[NL][NS];
        int   win;
        int   pop;
        int   mult;
        bit   rdy;
        bit   hit;
        bit   miss;
        reset = 0; frame_tick = tick; speed = 4'(spd); spawn_valid = sv; spawn_lanes = 4'(sl);
        strum = st; buttons = 4'(bt); px_x = 10'(x); px_y = 9'(y);
        rdy = model_ready();
        check("spawn_ready", int'(spawn_ready), int'(rdy));
        pv = m_valid;
        py = m_y;
        e.pl = 0;
        for (int l = 0; l < NL; l++) begin
            int xl = LANE_X0 + l * LANE_PITCH;
            if (x >= xl && x < xl + NOTE_H)
                for (int s = 0; s < NS; s++)
                    if (pv[l][s] && y >= py[l][s] && y < py[l][s] + NOTE_H) e.pl[l] = 1'b1;
        end
        e.pb = (y >= HIT_Y) && (y < HIT_Y + HIT_H) && (x >= LANE_X0)
            && (x < LANE_X0 + (NL - 1) * LANE_PITCH + NOTE_H);
        win  = model_win();
        hit  = st && win != 0 && bt == win;
        miss = st && win != 0 && bt != win;
        for (int l = 0; l < NL; l++) for (int s = 0; s < NS; s++) cleared[l][s] = 0;
        if (hit) begin
            pop = 0;
            for (int l = 0; l < NL; l++) begin
                if (win[l]) begin
                    pop++;
                    for (int s = 0; s < NS; s++) begin
                        if (pv[l][s] && note_in_window(py[l][s])) begin
                            cleared[l][s] = 1; m_valid[l][s] = 0; break;
                        end
                    end
                end
            end
            mult = 1 + ((m_streak / 8 > 3) ? 3 : m_streak / 8);
            m_score = m_score + pop * mult;
            if (m_score > 65535) m_score = 65535;
            m_streak = (m_streak < 255) ? m_streak + 1 : 255;
            m_hit_lanes = win;
        end
        if (miss) m_streak = 0;
        if (tick) begin
            for (int l = 0; l < NL; l++)
                for (int s = 0; s < NS; s++)
                    if (pv[l][s] && !cleared[l][s]) begin
                        if (py[l][s] + spd >= SCREEN_H) begin
                            m_valid[l][s] = 0; miss = 1; m_streak = 0;
                        end else m_y[l][s] = py[l][s] + spd;
                    end
        end
        if (sv && rdy) begin
            for (int l = 0; l < NL; l++)
                if (sl[l])
                    for (int s = 0; s < NS; s++)
                        if (!pv[l][s]) begin m_valid[l][s] = 1; m_y[l][s] = 0; break; end
        end
        e.hp = hit; e.mp = miss; e.hl = 4'(m_hit_lanes); e.sc = m_score; e.st = m_streak;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset(input int x, input int y);
        exp_t e;
        reset = 1; frame_tick = 1; speed = 4'd9; spawn_valid = 1; spawn_lanes = 4'hF;
        strum = 1; buttons = 4'h1; px_x = 10'(x); px_y = 9'(y);
        for (int l = 0; l < NL; l++) for (int s = 0; s < NS; s++) begin m_valid[l][s] = 0; m_y[l][s] = 0; end
        m_score = 0; m_streak = 0; m_hit_lanes = 0;
        e.hp = 0; e.mp = 0; e.hl = 0; e.sc = 0; e.st = 0; e.pl = 0; e.pb = 0;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        reset = 0;
    endtask

    task automatic idle(input bit tick, input int spd);
        step(tick, spd, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: each cycle's registered outputs are compared against the oldest expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (hit_pulse !== e.hp || miss_pulse !== e.mp || hit_lanes !== e.hl
                    || score !== 16'(e.sc) || streak !== 8'(e.st)
                    || pix_lane !== e.pl || pix_bar !== e.pb) begin
                    fails++;
                    $display("FAIL outputs @%0t: got hp=%b mp=%b hl=%h sc=%0d st=%0d pl=%h pb=%b expected hp=%b mp=%b hl=%h sc=%0d st=%0d pl=%h pb=%b",
                             $time, hit_pulse, miss_pulse, hit_lanes, score, streak, pix_lane, pix_bar,
                             e.hp, e.mp, e.hl, e.sc, e.st, e.pl, e.pb);
                end
            end
        end
    end

    initial begin
        reset = 1; frame_tick = 0; speed = 0; spawn_valid = 0; spawn_lanes = 0;
        strum = 0; buttons = 0; px_x = 0; px_y = 0;

        // Hit on lane 0 at y=310.
        do_reset(0, 0);
        check("ready_after_reset", int'(spawn_ready), 1);
        step(0, 10, 1, 4'b0001, 0, 0, 0, 0);
        repeat (31) idle(1, 10);
        step(0, 10, 0, 0, 1, 4'b0001, 0, 0);
        check("tp1_hit_pulse", int'(hit_pulse), 1);
        check("tp1_hit_lanes", int'(hit_lanes), 1);
        check("tp1_score", int'(score), 1);
        check("tp1_streak", int'(streak), 1);
        step(0, 10, 0, 0, 0, 0, 200, 320);
        check("tp1_pulse_one_cycle", int'(hit_pulse), 0);
        check("tp1_lane0_empty", int'(pix_lane), 0);

        // Wrong chord is a miss; the note stays and keeps moving.
        do_reset(0, 0);
        step(0, 10, 1, 4'b0001, 0, 0, 0, 0);
        repeat (31) idle(1, 10);
        step(0, 10, 0, 0, 1, 4'b0011, 0, 0);
        check("tp2_miss_pulse", int'(miss_pulse), 1);
        check("tp2_streak", int'(streak), 0);
        step(1, 10, 0, 0, 0, 0, 200, 330);
        check("tp2_note_stays", int'(pix_lane), 1);

        // Strum with nothing in the window is ignored.
        do_reset(0, 0);
        step(0, 10, 1, 4'b0001, 0, 0, 0, 0);
        step(0, 10, 0, 0, 1, 4'b0001, 0, 0);
        check("tp2_outside_no_hit", int'(hit_pulse), 0);
        check("tp2_outside_no_miss", int'(miss_pulse), 0);

        // Fall-off at y=480.
        do_reset(0, 0);
        step(0, 10, 1, 4'b0100, 0, 0, 0, 0);
        repeat (47) idle(1, 10);
        check("tp3_no_miss_yet", int'(miss_pulse), 0);
        idle(1, 10);
        check("tp3_falloff_miss", int'(miss_pulse), 1);
        idle(0, 10);
        check("tp3_miss_one_cycle", int'(miss_pulse), 0);

        // Full lane blocks spawns until the first note retires.
        do_reset(0, 0);
        repeat (4) step(1, 10, 1, 4'b0100, 0, 0, 0, 0);
        check("tp4_ready_low", int'(spawn_ready), 0);
        step(1, 10, 1, 4'b0100, 0, 0, 0, 0);
        repeat (43) idle(1, 10);
        check("tp4_still_full", int'(spawn_ready), 0);
        idle(1, 10);
        check("tp4_first_falloff", int'(miss_pulse), 1);
        check("tp4_ready_again", int'(spawn_ready), 1);

        // Eight single hits, then a two-lane chord at 2x.
        do_reset(0, 0);
        repeat (8) begin
            step(0, 10, 1, 4'b0001, 0, 0, 0, 0);
            repeat (31) idle(1, 10);
            step(0, 10, 0, 0, 1, 4'b0001, 0, 0);
        end
        check("tp5_score8", int'(score), 8);
        step(0, 10, 1, 4'b0011, 0, 0, 0, 0);
        repeat (31) idle(1, 10);
        step(0, 10, 0, 0, 1, 4'b0011, 0, 0);
        check("tp5_score", int'(score), 12);
        check("tp5_streak", int'(streak), 9);
        check("tp5_hit_lanes", int'(hit_lanes), 3);

        // Pixel queries and reset mid-flight.
        do_reset(0, 0);
        step(0, 10, 1, 4'b0010, 0, 0, 0, 0);
        step(0, 10, 0, 0, 0, 0, 270, 10);
        check("tp6_pix_lane1", int'(pix_lane), 2);
        step(0, 10, 0, 0, 0, 0, 270, 60);
        check("tp6_pix_below", int'(pix_lane), 0);
        step(0, 10, 0, 0, 0, 0, 200, 355);
        check("tp6_pix_bar", int'(pix_bar), 1);
        step(1, 10, 0, 0, 0, 0, 200, 355);
        do_reset(200, 355);
        check("tp6_rst_bar", int'(pix_bar), 0);
        check("tp6_rst_lane", int'(pix_lane), 0);
        check("tp6_rst_score", int'(score), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(int'($urandom_range(150, 560)), int'($urandom_range(0, 511)));
            end else begin
                bit tk = ($urandom_range(0, 1) == 1);
                int spd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
                bit sv = ($urandom_range(0, 5) == 0);
                int sl = int'($urandom_range(0, 15));
                bit st = ($urandom_range(0, 3) == 0);
                int bt = ($urandom_range(0, 1) == 1) ? model_win() : int'($urandom_range(0, 15));
                step(tk, spd, sv, sl, st, bt, int'($urandom_range(150, 560)), int'($urandom_range(0, 511)));
            end
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
